// File: rtl/spi_flash_erase_seq.sv
// -----------------------------------------------------------------------------
// spi_flash_erase_seq
//
// SPI-master sequencer that erases a W25Qxx-class flash. On an accepted start
// it issues Write-Enable (0x06), then the erase command, and then polls
// Read-Status-Register-1 (0x05) until WIP clears or the poll limit is hit.
// The erase command is chip erase (0xC7), 4 KB sector erase (0x20 + addr) or
// 64 KB block erase (0xD8 + addr). SCLK is produced internally, in SPI mode 0.
//
// Ports
//   clk       system clock
//   rst_n     synchronous active-low reset, sampled on the rising clk edge
//   start     single-cycle request, honoured only while idle
//   mode      0=chip, 1=sector, 2=block, 3=reserved (rejected with err)
//   addr      24-bit erase address (unused for chip erase)
//   busy      high for the whole erase sequence
//   done      one-cycle pulse: erase finished, WIP=0
//   err       one-cycle pulse: poll timeout or reserved mode
//   spi_clk   SCLK, idles low
//   cs        chip select, active low, idles high
//   spi_mosi  serial data to flash, MSB first
//   spi_miso  serial data from flash
// -----------------------------------------------------------------------------
module spi_flash_erase_seq #(
    parameter int          CLK_DIV  = 4,
    parameter int          CS_GAP   = 8,
    parameter logic [31:0] POLL_MAX = 32'd200_000_000,
    parameter int          POLL_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_clk,
    output logic        cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(CS_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WREN  = 3'd1,
        ST_GAP   = 3'd2,
        ST_ERASE = 3'd3,
        ST_POLL  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Erase frame contents, left-aligned in a 32-bit shift word.
    function automatic logic [31:0] erase_word(input logic [1:0] m, input logic [23:0] a);
        case (m)
            2'd1:    erase_word = {8'h20, a};
            2'd2:    erase_word = {8'hD8, a};
            default: erase_word = {8'hC7, 24'h00_0000};
        endcase
    endfunction

    // Erase frame length in bits.
    function automatic logic [5:0] erase_len(input logic [1:0] m);
        case (m)
            2'd1:    erase_len = 6'd32;
            2'd2:    erase_len = 6'd32;
            default: erase_len = 6'd8;
        endcase
    endfunction

    state_t            state_q,    state_d;
    state_t            nxt_q,      nxt_d;       // frame state to launch after GAP
    logic [1:0]        mode_q,     mode_d;
    logic [23:0]       addr_q,     addr_d;
    logic [31:0]       tx_q,       tx_d;        // tx_q[31] is the MOSI pin
    logic [5:0]        bit_cnt_q,  bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              miso_q,     miso_d;      // last sampled bit = status bit0 (WIP) at frame end
    logic              sclk_q,     sclk_d;
    logic              cs_q,       cs_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    logic              frame_end_s;
    logic              launch_s;
    logic [31:0]       launch_word_s;
    logic [5:0]        launch_len_s;
    logic [POLL_W-1:0] poll_inc_s;

    assign poll_inc_s = poll_cnt_q + POLL_W'(1);

    // Frame engine and sequencing FSM: next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        nxt_d         = nxt_q;
        mode_d        = mode_q;
        addr_d        = addr_q;
        tx_d          = tx_q;
        bit_cnt_d     = bit_cnt_q;
        div_cnt_d     = div_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        miso_d        = miso_q;
        sclk_d        = sclk_q;
        cs_d          = cs_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        frame_end_s   = 1'b0;
        launch_s      = 1'b0;
        launch_word_s = 32'h0000_0000;
        launch_len_s  = 6'd0;

        // Shared bit engine: runs only while a frame is open and bits remain.
        // The first divider period after cs falls is the cs-to-SCLK lead time.
        if (!cs_q && (bit_cnt_q != 6'd0)) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
                if (!sclk_q) begin
                    miso_d = spi_miso;
                end else if (bit_cnt_q == 6'd1) begin
                    frame_end_s = 1'b1;
                    bit_cnt_d   = 6'd0;
                    cs_d        = 1'b1;
                    tx_d        = 32'h0000_0000;
                end else begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    tx_d      = {tx_q[30:0], 1'b0};
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d        = mode;
                        addr_d        = addr;
                        busy_d        = 1'b1;
                        poll_cnt_d    = '0;
                        state_d       = ST_WREN;
                        launch_s      = 1'b1;
                        launch_word_s = {8'h06, 24'h00_0000};
                        launch_len_s  = 6'd8;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WREN: begin
                if (frame_end_s) begin
                    state_d   = ST_GAP;
                    nxt_d     = ST_ERASE;
                    gap_cnt_d = '0;
                end else begin
                    state_d = ST_WREN;
                end
            end
            ST_ERASE: begin
                if (frame_end_s) begin
                    state_d   = ST_GAP;
                    nxt_d     = ST_POLL;
                    gap_cnt_d = '0;
                end else begin
                    state_d = ST_ERASE;
                end
            end
            ST_POLL: begin
                if (frame_end_s) begin
                    if (!miso_q) begin
                        state_d = ST_FIN;
                    end else if (poll_inc_s >= POLL_LIM) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        poll_cnt_d = poll_inc_s;
                        state_d    = ST_GAP;
                        nxt_d      = ST_POLL;
                        gap_cnt_d  = '0;
                    end
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_MAX) begin
                    gap_cnt_d = '0;
                    case (nxt_q)
                        ST_ERASE: begin
                            state_d       = ST_ERASE;
                            launch_s      = 1'b1;
                            launch_word_s = erase_word(mode_q, addr_q);
                            launch_len_s  = erase_len(mode_q);
                        end
                        ST_POLL: begin
                            state_d       = ST_POLL;
                            launch_s      = 1'b1;
                            launch_word_s = {8'h05, 24'h00_0000};
                            launch_len_s  = 6'd16;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    endcase
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        // Opening a frame: cs falls, first MOSI bit is presented, SCLK low.
        if (launch_s) begin
            tx_d      = launch_word_s;
            bit_cnt_d = launch_len_s;
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            div_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            tx_d = tx_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nxt_q      <= ST_IDLE;
            mode_q     <= 2'd0;
            addr_q     <= 24'h00_0000;
            tx_q       <= 32'h0000_0000;
            bit_cnt_q  <= 6'd0;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            miso_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            miso_q     <= miso_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign spi_clk  = sclk_q;
    assign cs       = cs_q;
    assign spi_mosi = tx_q[31];

endmodule

// File: tb/tb_spi_flash_erase_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_erase_seq
//
// Directed bench for spi_flash_erase_seq (CLK_DIV=2, CS_GAP=8, POLL_MAX=5).
// A small flash model captures every frame sent on MOSI, answers RDSR with a
// status byte whose WIP bit stays set for a programmable number of polls, and
// measures SCLK half-periods and cs-high gaps.
// -----------------------------------------------------------------------------
module tb_spi_flash_erase_seq;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] addr;
    logic        busy;
    logic        done;
    logic        err;
    logic        spi_clk;
    logic        cs;
    logic        spi_mosi;
    logic        spi_miso;

    spi_flash_erase_seq #(
        .CLK_DIV  (CLK_DIV),
        .CS_GAP   (CS_GAP),
        .POLL_MAX (32'd5),
        .POLL_W   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .spi_clk  (spi_clk),
        .cs       (cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Written only by the sequence.
    int wip_ones  = 0;
    int rdsr_base = 0;

    // Written only by the monitor.
    logic [63:0] frm_q[$];
    int          len_q[$];
    logic [63:0] shreg    = 64'd0;
    int          rise_cnt = 0;
    int          rdsr_cnt = 0;
    int          cyc      = 0;
    int          last_evt = 0;
    int          rise_cyc = 0;
    bit          gap_armed = 1'b0;
    logic        cs_prev   = 1'b1;
    logic        sclk_prev = 1'b0;
    int          half_chk = 0, half_bad = 0, gap_chk = 0, gap_bad = 0;
    int          done_cnt = 0, err_cnt = 0, ovl_cnt = 0;

    function automatic logic miso_fn(input int k, input logic [7:0] st);
        logic [2:0] idx;
        idx = 3'(15 - k);
        if (k >= 8 && k < 16) return st[idx];
        return 1'b0;
    endfunction

    logic       wip_s;
    logic [7:0] status_s;
    assign wip_s    = ((rdsr_cnt - rdsr_base) < wip_ones);
    assign status_s = {1'b1, 6'b000000, wip_s};
    assign spi_miso = miso_fn(rise_cnt, status_s);

    // Flash model and timing monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs_prev && !cs) begin
            rise_cnt = 0;
            shreg    = 64'd0;
            if (gap_armed) begin
                gap_chk = gap_chk + 1;
                if (cyc - rise_cyc != CS_GAP) gap_bad = gap_bad + 1;
            end
            last_evt = cyc;
        end
        if (!cs && !sclk_prev && spi_clk) begin
            shreg    = {shreg[62:0], spi_mosi};
            rise_cnt = rise_cnt + 1;
        end
        if (rst_n && !cs_prev && (spi_clk != sclk_prev)) begin
            half_chk = half_chk + 1;
            if (cyc - last_evt != CLK_DIV) half_bad = half_bad + 1;
            last_evt = cyc;
        end
        if (!cs_prev && cs) begin
            frm_q.push_back(shreg);
            len_q.push_back(rise_cnt);
            if (rise_cnt == 16 && shreg[15:8] == 8'h05) rdsr_cnt = rdsr_cnt + 1;
            rise_cyc  = cyc;
            gap_armed = busy;
        end else if (!busy) begin
            gap_armed = 1'b0;
        end
        if (done) done_cnt = done_cnt + 1;
        if (err)  err_cnt  = err_cnt + 1;
        if (((done || err) && busy) || (done && err)) ovl_cnt = ovl_cnt + 1;
        cs_prev   = cs;
        sclk_prev = spi_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int idx, input logic [63:0] d, input int l);
        logic [63:0] od;
        logic [63:0] ol;
        od = (idx < frm_q.size()) ? frm_q[idx] : 64'hxxxx_xxxx_xxxx_xxxx;
        ol = (idx < len_q.size()) ? 64'(len_q[idx]) : 64'hxxxx_xxxx_xxxx_xxxx;
        check({tag, "_data"}, od, d);
        check({tag, "_len"}, ol, 64'(l));
    endtask

    task automatic start_pulse(input logic [1:0] m, input logic [23:0] a);
        start = 1'b1;
        mode  = m;
        addr  = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget, output bit got_done, output bit got_err);
        bit seen;
        seen     = 1'b0;
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                seen     = 1'b1;
                got_done = done;
                got_err  = err;
                break;
            end
        end
        check({tag, "_end_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        bit d, e;
        int fb, db, eb, hb, hbb, gb, gbb, ob;
        bit found;

        rst_n = 1'b0; start = 1'b0; mode = 2'd0; addr = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err),  64'd0);
        check("rst_sclk", 64'(spi_clk), 64'd0);
        check("rst_cs",   64'(cs),   64'd1);
        check("rst_mosi", 64'(spi_mosi), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: chip erase, WIP=1 for three polls
        fb = frm_q.size(); db = done_cnt; eb = err_cnt; hb = half_chk; hbb = half_bad;
        gb = gap_chk; gbb = gap_bad; ob = ovl_cnt;
        rdsr_base = rdsr_cnt; wip_ones = 3;
        start_pulse(2'd0, 24'h000000);
        check("t1_busy", 64'(busy), 64'd1);
        wait_end("t1", 3000, d, e);
        check("t1_done", 64'(d), 64'd1);
        check("t1_err",  64'(e), 64'd0);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        check("t1_nframes", 64'(frm_q.size() - fb), 64'd6);
        chk_frame("t1_wren", fb + 0, 64'h06, 8);
        chk_frame("t1_erase", fb + 1, 64'hC7, 8);
        for (int i = 2; i < 6; i++) chk_frame("t1_rdsr", fb + i, 64'h0500, 16);
        check("t1_done_cnt", 64'(done_cnt - db), 64'd1);
        check("t1_err_cnt",  64'(err_cnt - eb), 64'd0);
        check("t1_half_chk", 64'(half_chk - hb), 64'd160);
        check("t1_half_bad", 64'(half_bad - hbb), 64'd0);
        check("t1_gap_chk",  64'(gap_chk - gb), 64'd5);
        check("t1_gap_bad",  64'(gap_bad - gbb), 64'd0);
        check("t1_overlap",  64'(ovl_cnt - ob), 64'd0);

        // 2: sector erase
        fb = frm_q.size(); rdsr_base = rdsr_cnt; wip_ones = 0;
        start_pulse(2'd1, 24'h123456);
        wait_end("t2", 3000, d, e);
        check("t2_done", 64'(d), 64'd1);
        repeat (2) @(negedge clk);
        check("t2_nframes", 64'(frm_q.size() - fb), 64'd3);
        chk_frame("t2_erase", fb + 1, 64'h2012_3456, 32);

        // 3: block erase at top address
        fb = frm_q.size(); rdsr_base = rdsr_cnt; wip_ones = 0;
        start_pulse(2'd2, 24'hFFFFFF);
        wait_end("t3", 3000, d, e);
        check("t3_done", 64'(d), 64'd1);
        repeat (2) @(negedge clk);
        chk_frame("t3_erase", fb + 1, 64'hD8FF_FFFF, 32);
        chk_frame("t3_rdsr", fb + 2, 64'h0500, 16);

        // 4: timeout after POLL_MAX polls
        fb = frm_q.size(); db = done_cnt; eb = err_cnt; ob = ovl_cnt;
        rdsr_base = rdsr_cnt; wip_ones = 100;
        start_pulse(2'd0, 24'h000000);
        wait_end("t4", 5000, d, e);
        check("t4_err", 64'(e), 64'd1);
        check("t4_done", 64'(d), 64'd0);
        check("t4_busy_at_err", 64'(busy), 64'd0);
        @(negedge clk);
        check("t4_err_pulse", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        check("t4_cs", 64'(cs), 64'd1);
        check("t4_rdsr_frames", 64'(rdsr_cnt - rdsr_base), 64'd5);
        check("t4_nframes", 64'(frm_q.size() - fb), 64'd7);
        check("t4_done_cnt", 64'(done_cnt - db), 64'd0);
        check("t4_err_cnt", 64'(err_cnt - eb), 64'd1);
        check("t4_overlap", 64'(ovl_cnt - ob), 64'd0);

        // 5: reserved mode, then start during busy
        fb = frm_q.size();
        start_pulse(2'd3, 24'h000000);
        check("t5_err", 64'(err), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("t5_err_pulse", 64'(err), 64'd0);
        repeat (10) @(negedge clk);
        check("t5_no_frame", 64'(frm_q.size() - fb), 64'd0);
        check("t5_busy_idle", 64'(busy), 64'd0);
        rdsr_base = rdsr_cnt; wip_ones = 0;
        start_pulse(2'd1, 24'h00AA55);
        repeat (20) @(negedge clk);
        start_pulse(2'd0, 24'h000000);
        wait_end("t5", 3000, d, e);
        check("t5_done", 64'(d), 64'd1);
        repeat (2) @(negedge clk);
        check("t5_nframes", 64'(frm_q.size() - fb), 64'd3);
        chk_frame("t5_wren", fb + 0, 64'h06, 8);
        chk_frame("t5_erase", fb + 1, 64'h2000_AA55, 32);

        // 6: reset in the 10th bit of the erase frame, then a clean run
        fb = frm_q.size(); rdsr_base = rdsr_cnt; wip_ones = 0;
        start_pulse(2'd1, 24'hABCDEF);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frm_q.size() == fb + 1 && rise_cnt == 10 && !cs) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach_bit10", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_cs", 64'(cs), 64'd1);
        check("t6_sclk", 64'(spi_clk), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_mosi", 64'(spi_mosi), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        fb = frm_q.size(); rdsr_base = rdsr_cnt; wip_ones = 0;
        start_pulse(2'd0, 24'h000000);
        wait_end("t6", 3000, d, e);
        check("t6_done", 64'(d), 64'd1);
        repeat (2) @(negedge clk);
        check("t6_nframes", 64'(frm_q.size() - fb), 64'd3);
        chk_frame("t6_wren", fb + 0, 64'h06, 8);
        chk_frame("t6_erase", fb + 1, 64'hC7, 8);
        chk_frame("t6_rdsr", fb + 2, 64'h0500, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
